// File: rtl/fir_pkg.sv
// Shared constants for the 5-tap DSP48A1-style FIR filter family.
package fir_pkg;
    localparam int FIR_IN_WIDTH  = 18;
    localparam int FIR_OUT_WIDTH = 48;
    localparam int NTAPS         = 5;
    localparam int LATENCY       = 4;
endpackage

// File: rtl/fir_1d_5_s6_dsp_tap_slice.sv
// DSP48A1-style slice: two registered signed multiplies feeding a registered
// post-adder whose second operand is either the sibling product or PCIN.
module dsp_tap_slice
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = FIR_IN_WIDTH,
    parameter int OUT_WIDTH = FIR_OUT_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic signed [IN_WIDTH-1:0]  a0,
    input  logic signed [IN_WIDTH-1:0]  b0,
    input  logic signed [IN_WIDTH-1:0]  a1,
    input  logic signed [IN_WIDTH-1:0]  b1,
    input  logic signed [OUT_WIDTH-1:0] pcin,
    input  logic                        sel_pcin,
    output logic signed [OUT_WIDTH-1:0] p
);
    localparam int PW = 2 * IN_WIDTH;

    logic signed [PW-1:0]        m0;
    logic signed [PW-1:0]        m1;
    logic signed [OUT_WIDTH-1:0] c_sel;

    // Products sign-extend into the post-adder; the sum wraps at OUT_WIDTH.
    always_comb begin
        c_sel = sel_pcin ? pcin : OUT_WIDTH'(m1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m0 <= '0;
            m1 <= '0;
            p  <= '0;
        end else begin
            m0 <= PW'(a0) * PW'(b0);
            m1 <= PW'(a1) * PW'(b1);
            p  <= OUT_WIDTH'(m0) + c_sel;
        end
    end
endmodule

// File: rtl/fir_1d_5_s6.sv
// 5-tap pipelined FIR with cascade ports: delay line, multiply, pairwise add,
// final add. Y_STRB tracks each accepted sample through the four stages.
module fir_1d_5_s6
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = FIR_IN_WIDTH,
    parameter int OUT_WIDTH = FIR_OUT_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic signed [IN_WIDTH-1:0]  H0,
    input  logic signed [IN_WIDTH-1:0]  H1,
    input  logic signed [IN_WIDTH-1:0]  H2,
    input  logic signed [IN_WIDTH-1:0]  H3,
    input  logic signed [IN_WIDTH-1:0]  H4,
    input  logic signed [IN_WIDTH-1:0]  X,
    input  logic                        X_STRB,
    input  logic signed [OUT_WIDTH-1:0] PCIN,
    output logic signed [IN_WIDTH-1:0]  BCOUT,
    output logic signed [OUT_WIDTH-1:0] Y,
    output logic signed [OUT_WIDTH-1:0] PCOUT,
    output logic                        Y_STRB
);
    logic signed [IN_WIDTH-1:0]  xd [NTAPS];
    logic [LATENCY-1:0]          strb_pipe;
    logic signed [OUT_WIDTH-1:0] s01;
    logic signed [OUT_WIDTH-1:0] s23;
    logic signed [OUT_WIDTH-1:0] s4p;

    // Delay line only advances on accepted samples; the strobe pipe runs freely.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < NTAPS; k++) begin
                xd[k] <= '0;
            end
            strb_pipe <= '0;
        end else begin
            if (X_STRB) begin
                xd[0] <= X;
                for (int k = 1; k < NTAPS; k++) begin
                    xd[k] <= xd[k-1];
                end
            end
            strb_pipe <= {strb_pipe[LATENCY-2:0], X_STRB};
        end
    end

    dsp_tap_slice #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_pair01 (
        .CLK      (CLK),
        .RST      (RST),
        .a0       (H0),
        .b0       (xd[0]),
        .a1       (H1),
        .b1       (xd[1]),
        .pcin     ('0),
        .sel_pcin (1'b0),
        .p        (s01)
    );

    dsp_tap_slice #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_pair23 (
        .CLK      (CLK),
        .RST      (RST),
        .a0       (H2),
        .b0       (xd[2]),
        .a1       (H3),
        .b1       (xd[3]),
        .pcin     ('0),
        .sel_pcin (1'b0),
        .p        (s23)
    );

    // The odd tap pairs with the cascade input instead of a second product.
    dsp_tap_slice #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_tap4 (
        .CLK      (CLK),
        .RST      (RST),
        .a0       (H4),
        .b0       (xd[4]),
        .a1       ('0),
        .b1       ('0),
        .pcin     (PCIN),
        .sel_pcin (1'b1),
        .p        (s4p)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Y <= '0;
        end else begin
            Y <= s01 + s23 + s4p;
        end
    end

    assign PCOUT  = Y;
    assign BCOUT  = xd[NTAPS-1];
    assign Y_STRB = strb_pipe[LATENCY-1];
endmodule

// File: tb/tb_fir_1d_5_s6.sv
// Directed bench for fir_1d_5_s6: behavioural FIR model feeds a scoreboard
// queue that is drained whenever the DUT raises Y_STRB.
module tb_fir_1d_5_s6;
    logic               CLK;
    logic               RST;
    logic signed [17:0] H0, H1, H2, H3, H4;
    logic signed [17:0] X;
    logic               X_STRB;
    logic signed [47:0] PCIN;
    logic signed [17:0] BCOUT;
    logic signed [47:0] Y;
    logic signed [47:0] PCOUT;
    logic               Y_STRB;

    int checks = 0;
    int errors = 0;

    int                 h_m  [5];
    int                 x_m  [5];
    longint             pcin_m;
    logic signed [47:0] expq [$];
    logic signed [47:0] mon_exp;
    logic signed [47:0] wrap_exp;

    fir_1d_5_s6 dut (
        .CLK    (CLK),
        .RST    (RST),
        .H0     (H0),
        .H1     (H1),
        .H2     (H2),
        .H3     (H3),
        .H4     (H4),
        .X      (X),
        .X_STRB (X_STRB),
        .PCIN   (PCIN),
        .BCOUT  (BCOUT),
        .Y      (Y),
        .PCOUT  (PCOUT),
        .Y_STRB (Y_STRB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic signed [47:0] model_y();
        longint acc;
        acc = pcin_m;
        for (int k = 0; k < 5; k++) begin
            acc += longint'(h_m[k]) * longint'(x_m[k]);
        end
        return 48'(acc);
    endfunction

    task automatic checkOutput(input string tag, input logic signed [47:0] obs,
                               input logic signed [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int x, input bit strb);
        X      = 18'(x);
        X_STRB = strb;
        if (strb) begin
            for (int k = 4; k > 0; k--) x_m[k] = x_m[k-1];
            x_m[0] = x;
            expq.push_back(model_y());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idleCycles(input int n);
        X_STRB = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic setCoeffs(input int c0, input int c1, input int c2, input int c3, input int c4);
        h_m[0] = c0; h_m[1] = c1; h_m[2] = c2; h_m[3] = c3; h_m[4] = c4;
        H0 = 18'(c0); H1 = 18'(c1); H2 = 18'(c2); H3 = 18'(c3); H4 = 18'(c4);
    endtask

    task automatic setPcin(input longint v);
        pcin_m = v;
        PCIN   = 48'(v);
    endtask

    task automatic drainCheck(input string tag);
        idleCycles(6);
        checkOutput(tag, 48'(expq.size()), 48'sd0);
    endtask

    // Scoreboard side: every output strobe must match the oldest pending result.
    always @(negedge CLK) begin
        if (RST === 1'b1 && Y_STRB === 1'b1) begin
            checkOutput("strobe_expected", 48'(expq.size() != 0), 48'sd1);
            if (expq.size() != 0) begin
                mon_exp = expq.pop_front();
                checkOutput("y_strobe", Y, mon_exp);
                checkOutput("pcout_strobe", PCOUT, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 5; k++) x_m[k] = 0;
        RST    = 1'b0;
        X      = '0;
        X_STRB = 1'b0;
        setPcin(0);
        setCoeffs(256, 1, 2, 4, 8);

        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            X      = 18'(i * 37 + 5);
            X_STRB = 1'b1;
            @(posedge CLK);
            #1;
        end
        checkOutput("rst_y", Y, 48'sd0);
        checkOutput("rst_pcout", PCOUT, 48'sd0);
        checkOutput("rst_bcout", BCOUT, 48'sd0);
        checkOutput("rst_ystrb", Y_STRB, 48'sd0);
        X_STRB = 1'b0;
        #2 RST = 1'b1;
        @(posedge CLK);
        #1;
        idleCycles(4);

        // Impulse through distinct coefficients.
        applyStimulus(1, 1'b1);
        checkOutput("imp_lat_e0", Y, 48'sd0);
        applyStimulus(0, 1'b1);
        checkOutput("imp_lat_e1", Y, 48'sd0);
        applyStimulus(0, 1'b1);
        checkOutput("imp_lat_e2", Y, 48'sd0);
        applyStimulus(0, 1'b1);
        checkOutput("imp_first_y", Y, 48'sd256);
        checkOutput("imp_first_strb", Y_STRB, 48'sd1);
        applyStimulus(0, 1'b1);
        applyStimulus(0, 1'b1);
        drainCheck("imp_drain");

        // Ramp with a three-cycle gap after sample 7.
        setCoeffs(256, 256, 256, 256, 256);
        idleCycles(4);
        for (int k = 0; k <= 7; k++) begin
            applyStimulus(k, 1'b1);
            if (k >= 4) checkOutput("ramp_bcout", BCOUT, 48'(k - 4));
            if (k == 7) checkOutput("ramp_y", Y, 48'(256 * (5 * (k - 3) - 10)));
        end
        for (int g = 0; g < 3; g++) begin
            idleCycles(1);
            checkOutput("gap_bcout", BCOUT, 48'sd3);
        end
        for (int k = 8; k <= 13; k++) begin
            applyStimulus(k, 1'b1);
            checkOutput("resume_bcout", BCOUT, 48'(k - 4));
            if (k <= 10) begin
                checkOutput("gap_y_frozen", Y, 48'sd6400);
                checkOutput("gap_ystrb", Y_STRB, 48'sd0);
            end else begin
                checkOutput("resume_y", Y, 48'(256 * (5 * (k - 3) - 10)));
                checkOutput("resume_ystrb", Y_STRB, 48'sd1);
            end
        end
        drainCheck("ramp_drain");

        // Most-negative operands, then a wrap through PCIN.
        setCoeffs(-131072, -131072, -131072, -131072, -131072);
        idleCycles(4);
        for (int i = 0; i < 5; i++) applyStimulus(-131072, 1'b1);
        drainCheck("signed_drain");
        checkOutput("signed_y", Y, 48'sd85899345920);
        setPcin(longint'(48'h7FFF_FFFF_FFFF));
        idleCycles(3);
        wrap_exp = 48'h8013_FFFF_FFFF;
        checkOutput("wrap_y", Y, wrap_exp);
        checkOutput("wrap_sign", 48'(Y[47]), 48'sd1);
        applyStimulus(-131072, 1'b1);
        drainCheck("wrap_drain");

        // Cascade input alone.
        setCoeffs(0, 0, 0, 0, 0);
        setPcin(0);
        idleCycles(4);
        setPcin(1000);
        idleCycles(1);
        checkOutput("casc_edge1", Y, 48'sd0);
        idleCycles(1);
        checkOutput("casc_y", Y, 48'sd1000);
        checkOutput("casc_pcout", PCOUT, 48'sd1000);

        // Asynchronous reset mid-stream.
        setPcin(0);
        setCoeffs(1, 2, 3, 4, 5);
        idleCycles(4);
        for (int i = 1; i <= 6; i++) applyStimulus(i * 10, 1'b1);
        #1 RST = 1'b0;
        #1;
        checkOutput("arst_y", Y, 48'sd0);
        checkOutput("arst_pcout", PCOUT, 48'sd0);
        checkOutput("arst_bcout", BCOUT, 48'sd0);
        checkOutput("arst_ystrb", Y_STRB, 48'sd0);
        expq.delete();
        for (int k = 0; k < 5; k++) x_m[k] = 0;
        X_STRB = 1'b0;
        #3 RST = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 1; i <= 3; i++) applyStimulus(i * 100, 1'b1);
        drainCheck("arst_restart_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
